fir_stream: RTL and testbench
=============================

# fir_stream

Parametrised streaming FIR filter, the next generation of the team's `Fir` block. It adds generic tap count and widths, valid/ready handshaking on the sample and result streams, and a counted coefficient-load phase with a completion flag. Output is rounded and saturated. It sits between a sample source and a downstream consumer that may apply backpressure.

## Interface
- DATA_WIDTH, 16, signed sample width
- COEF_WIDTH, 16, signed coefficient width
- TAPS, 8, number of taps (≥2)
- OUT_WIDTH, 32, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before output (0..ACC_W-1)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  global advance; 0 freezes all state
- control  in  1  0 = coefficient load mode, 1 = filter mode
- coef_in  in  COEF_WIDTH  coefficient word
- coef_valid  in  1  coef_in valid this cycle
- coef_done  out  1  all TAPS coefficients loaded
- x_in  in  DATA_WIDTH  input sample
- x_valid  in  1  sample valid
- x_ready  out  1  block accepts sample
- y_out  out  OUT_WIDTH  filtered result
- y_valid  out  1  y_out valid
- y_ready  in  1  consumer accepts y_out
- y_sat  out  1  y_out was saturated (qualified by y_valid)

## Operation
- ACC_W = DATA_WIDTH + COEF_WIDTH + clog2(TAPS); all arithmetic is signed two's complement.
- y[n] = Σ_{i=0..TAPS-1} coef[i]·x[n-i]; coef[0] multiplies the newest sample.
- States: LOAD and RUN. Reset enters LOAD.
  - LOAD → RUN when control=1 and coef_done=1.
  - RUN → LOAD when control=0.
  - In LOAD with control=1 and coef_done=0, the block stays in LOAD and x_ready=0.
- Entering LOAD from RUN: load index=0, coef_done=0, delay line cleared to 0, all pipeline valid bits cleared. In-flight results are discarded.
- LOAD: each cycle with enable & coef_valid writes coef[idx] and increments idx.
  - After the write of idx=TAPS-1, coef_done=1 and idx wraps to 0.
  - Further writes overwrite from coef[0] onward; coef_done stays 1.
  - coef_valid is ignored in RUN.
- advance = enable & (!y_valid | y_ready).
- x_ready = advance & (state==RUN).
- A sample is accepted on x_valid & x_ready. It shifts into the delay line; the oldest sample drops.
- Pipeline stages:
  - Stage 1 registers the TAPS products and a valid bit.
  - Stage 2 sums them, rounds, saturates, and registers y_out, y_sat and y_valid.
  - Every stage updates only on advance. If advance=1 and no sample is accepted, a bubble (valid=0) enters.
- Rounding: if SHIFT>0, add 1<<(SHIFT-1) to the accumulator before the arithmetic shift (round half up). If SHIFT=0, no rounding.
- Saturation: if the shifted value exceeds the OUT_WIDTH range, clamp to max positive or min negative and set y_sat=1; otherwise y_sat=0.
- enable=0 holds all registers, including coefficients, idx, state and outputs.

## Timing
- Reset (synchronous, one edge) clears:
  - outputs: y_out=0, y_valid=0, y_sat=0, coef_done=0, x_ready=0
  - internal state: coefficients=0, delay line=0, idx=0, state=LOAD
- Reset has priority over every other input, including mid-load and mid-stream.
- Latency: a sample accepted at edge k produces y_valid=1 with its y_out after edge k+2, provided no stall occurs.
- Throughput: one sample per cycle while y_ready=1.
- Backpressure: while y_valid=1 and y_ready=0, y_out, y_sat and y_valid hold, x_ready=0 combinationally in the same cycle, and no data is lost or duplicated.
- coef_done rises after the edge that writes coef[TAPS-1]. The earliest x_ready=1 is the cycle after RUN is entered.
- control falling in RUN: state=LOAD, y_valid=0 and x_ready=0 after the next enabled edge.

## Test plan
- Reset: assert reset for 2 cycles with random inputs → all outputs 0 and x_ready=0; with control=1, no sample is accepted until coefficients are loaded.
- Impulse (TAPS=8, SHIFT=0): load coef 1..8, set control=1, feed x=1 then 10 zeros with y_ready=1 → y = 1,2,3,4,5,6,7,8,0,0; the first y_valid follows 2 edges after acceptance.
- Step: same coefs, x=1 constant → y = 1,3,6,10,15,21,28,36,36,…; SHIFT=2 with the same input → 0,1,2,3,4,5,7,9,9 (half-up rounding).
- Backpressure: stream x=1..20 with y_ready low for 3 cycles mid-stream → x_ready low during the stall, y_out held constant, and the output sequence matches the reference model with no gaps or repeats.
- Saturation (OUT_WIDTH=16, SHIFT=0): all coefs 0x7FFF, x=0x7FFF → y_out=0x7FFF, y_sat=1; x=0x8000 → y_out=0x8000, y_sat=1; x=0 → y_sat=0.
- Reload mid-run: drop control with results in flight → y_valid=0 after the next edge and coef_done=0; load coefs all 1, raise control, feed x=2 → first y=2, because no old samples survive in the delay line.

Source files
------------

// File: rtl/fir_stream.sv
// rtl/fir_stream.sv - streaming FIR filter with counted coefficient load,
// valid/ready handshake, round-half-up and output saturation.
module fir_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  control,
  input  logic [COEF_WIDTH-1:0] coef_in,
  input  logic                  coef_valid,
  output logic                  coef_done,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic [OUT_WIDTH-1:0]  y_out,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  y_sat
);

  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int IDX_W  = $clog2(TAPS);
  // Extra headroom so the rounding add and the range compare never wrap.
  localparam int EXT_W  = (ACC_W + 1 > OUT_WIDTH) ? ACC_W + 2 : OUT_WIDTH + 1;

  localparam logic [EXT_W-1:0] ONE = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MAX = $signed((ONE << (OUT_WIDTH - 1)) - ONE);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [EXT_W-1:0] RND     = $signed((ONE << SHIFT) >> 1);

  typedef enum logic {LOAD, RUN} state_t;

  state_t state, state_next;

  logic signed [COEF_WIDTH-1:0] coef [TAPS];
  logic signed [DATA_WIDTH-1:0] dly  [TAPS];
  logic signed [PROD_W-1:0]     prod [TAPS];
  logic                         dly_valid;
  logic                         prod_valid;
  logic [IDX_W-1:0]             idx;

  logic advance, accept, enter_load, coef_wr;
  logic signed [EXT_W-1:0] acc, rnd, shifted;
  logic sat_hi, sat_lo;
  logic [OUT_WIDTH-1:0] y_next;

  assign advance    = enable & (~y_valid | y_ready);
  assign x_ready    = advance & (state == RUN);
  assign accept     = x_valid & x_ready;
  assign enter_load = enable & (state == RUN) & ~control;
  assign coef_wr    = enable & (state == LOAD) & coef_valid;

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (control && coef_done) state_next = RUN;
      RUN:     if (!control) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else if (enable) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      idx       <= '0;
      coef_done <= 1'b0;
    end else if (enter_load) begin
      idx       <= '0;
      coef_done <= 1'b0;
    end else if (coef_wr) begin
      coef[idx] <= coef_in;
      if (idx == IDX_W'(TAPS - 1)) begin
        idx       <= '0;
        coef_done <= 1'b1;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Leaving RUN flushes the delay line and every valid bit so no stale sample
  // can leak into the first result computed with the new coefficients.
  always_ff @(posedge clk) begin
    if (reset || enter_load) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
      dly_valid <= 1'b0;
    end else if (advance) begin
      dly_valid <= accept;
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= x_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
      prod_valid <= 1'b0;
    end else if (enter_load) begin
      prod_valid <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= PROD_W'(dly[i]) * PROD_W'(coef[i]);
      prod_valid <= dly_valid;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + EXT_W'(prod[i]);
    rnd     = acc + RND;
    shifted = rnd >>> SHIFT;
    sat_hi  = shifted > OUT_MAX;
    sat_lo  = shifted < OUT_MIN;
    if (sat_hi)      y_next = OUT_MAX[OUT_WIDTH-1:0];
    else if (sat_lo) y_next = OUT_MIN[OUT_WIDTH-1:0];
    else             y_next = shifted[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_out   <= '0;
      y_sat   <= 1'b0;
      y_valid <= 1'b0;
    end else if (enter_load) begin
      y_valid <= 1'b0;
    end else if (advance) begin
      y_valid <= prod_valid;
      if (prod_valid) begin
        y_out <= y_next;
        y_sat <= sat_hi | sat_lo;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// tb/tb_fir_stream.sv - randomized bench for fir_stream: two instances
// (SHIFT=0/OUT=32 and SHIFT=2/OUT=16) checked against a queue-based model.
module tb_fir_stream;

  localparam int TAPS = 8;

  logic        clk = 1'b0;
  logic        reset, enable, control, coef_valid, x_valid, y_ready;
  logic [15:0] coef_in, x_in;
  logic        coef_done0, x_ready0, y_valid0, y_sat0;
  logic [31:0] y_out0;
  logic        coef_done1, x_ready1, y_valid1, y_sat1;
  logic [15:0] y_out1;

  always #5 clk = ~clk;

  fir_stream #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .OUT_WIDTH(32), .SHIFT(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .control(control),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_done(coef_done0),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready0),
    .y_out(y_out0), .y_valid(y_valid0), .y_ready(y_ready), .y_sat(y_sat0));

  fir_stream #(.DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .OUT_WIDTH(16), .SHIFT(2)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .control(control),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_done(coef_done1),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready1),
    .y_out(y_out1), .y_valid(y_valid1), .y_ready(y_ready), .y_sat(y_sat1));

  longint mcoef [TAPS];
  longint hist  [TAPS];
  longint load_buf [TAPS];
  int     midx;
  bit     mdone;
  longint expq[$];
  longint log0[$];
  longint log1[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     p_gap = 0, p_dis = 0, p_stall = 0;
  longint m_s, m_v;
  bit     m_st;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic void model_out(input longint s, input int sh, input int ow,
                                    output longint v, output bit sat);
    longint mx, mn;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
    s = s >>> sh;
    v = s;
    sat = 0;
    if (s > mx) begin v = mx; sat = 1; end
    else if (s < mn) begin v = mn; sat = 1; end
  endfunction

  task automatic model_flush();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    expq.delete();
    log0.delete();
    log1.delete();
    midx = 0;
    mdone = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (x_valid && x_ready0) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = $signed(x_in);
        m_s = 0;
        for (int i = 0; i < TAPS; i++) m_s += mcoef[i] * hist[i];
        expq.push_back(m_s);
      end
      if (y_valid0) begin
        if (expq.size() == 0) check("unexpected_y0", 1, 0);
        else begin
          model_out(expq[0], 0, 32, m_v, m_st);
          check("y0", $signed(y_out0), m_v);
          check("y0_sat", y_sat0, m_st);
        end
      end
      if (y_valid1) begin
        if (expq.size() == 0) check("unexpected_y1", 1, 0);
        else begin
          model_out(expq[0], 2, 16, m_v, m_st);
          check("y1", $signed(y_out1), m_v);
          check("y1_sat", y_sat1, m_st);
        end
      end
      if (y_valid0 && y_ready && enable && expq.size() > 0) begin
        log0.push_back($signed(y_out0));
        log1.push_back(y_valid1 ? longint'($signed(y_out1)) : 99999);
        void'(expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      reset = 1; enable = 1'($urandom); control = 1'($urandom);
      coef_valid = 1'($urandom); coef_in = 16'($urandom);
      x_valid = 1'($urandom); x_in = 16'($urandom); y_ready = 1'($urandom);
    end
    tick();
    check("rst_y_out", y_out0, 0);
    check("rst_y_valid", y_valid0, 0);
    check("rst_y_sat", y_sat0, 0);
    check("rst_coef_done", coef_done0, 0);
    check("rst_x_ready", x_ready0, 0);
    check("rst_y_out1", y_out1, 0);
    reset = 0; control = 0; coef_valid = 0; x_valid = 0; enable = 1; y_ready = 1;
    for (int i = 0; i < TAPS; i++) mcoef[i] = 0;
    model_flush();
  endtask

  task automatic load_coefs(input int extra);
    int guard;
    bit written;
    tick();
    control = 0; x_valid = 0; coef_valid = 0; enable = 1;
    tick();
    check("load_y_valid", y_valid0, 0);
    check("load_coef_done", coef_done0, 0);
    model_flush();
    for (int k = 0; k < TAPS + extra; k++) begin
      written = 0;
      guard = 0;
      while (!written && guard < 100) begin
        if (guard > 0 || k > 0) tick();
        check("coef_done_progress", coef_done0, mdone);
        coef_valid = 1;
        coef_in = load_buf[k % TAPS][15:0] + 16'(k / TAPS);
        enable = ($urandom_range(0, 99) >= p_dis);
        if (enable) begin
          mcoef[midx] = $signed(coef_in);
          midx = (midx + 1) % TAPS;
          if (midx == 0) mdone = 1;
          written = 1;
        end
        guard++;
      end
      if (!written) check("load_timeout", 0, 1);
    end
    tick();
    coef_valid = 0; enable = 1;
    check("coef_done0", coef_done0, mdone);
    check("coef_done1", coef_done1, mdone);
  endtask

  task automatic run_mode();
    tick();
    control = 1; enable = 1;
  endtask

  task automatic send(input longint xv);
    int guard = 0;
    bit done = 0;
    while (!done && guard < 300) begin
      tick();
      x_in = xv[15:0];
      x_valid = ($urandom_range(0, 99) >= p_gap);
      enable = ($urandom_range(0, 99) >= p_dis);
      y_ready = ($urandom_range(0, 99) >= p_stall);
      #1;
      if (x_valid && x_ready0) done = 1;
      guard++;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    tick();
    x_valid = 0; enable = 1; y_ready = 1;
    while ((expq.size() != 0 || y_valid0) && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("drain_timeout", 0, 1);
  endtask

  longint imp_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
  longint step0   [9]  = '{1, 3, 6, 10, 15, 21, 28, 36, 36};
  longint step1   [9]  = '{0, 1, 2, 3, 4, 5, 7, 9, 9};
  longint hold;

  initial begin
    reset = 1; enable = 1; control = 0; coef_valid = 0; coef_in = 0;
    x_valid = 0; x_in = 0; y_ready = 1;
    model_flush();
    do_reset();

    // coefficients not loaded: RUN must not be entered
    control = 1; x_valid = 1; x_in = 5;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("x_ready_unloaded", x_ready0, 0);
    end
    x_valid = 0;

    // impulse and latency
    for (int i = 0; i < TAPS; i++) load_buf[i] = i + 1;
    p_dis = 30;
    load_coefs(0);
    p_dis = 0;
    run_mode();
    send(1);
    tick(); x_valid = 0;
    check("lat_k", y_valid0, 0);
    tick();
    check("lat_k1", y_valid0, 0);
    tick();
    check("lat_k2_valid", y_valid0, 1);
    check("lat_k2_y", $signed(y_out0), 1);
    for (int i = 0; i < 10; i++) send(0);
    drain();
    check("imp_count", log0.size(), 11);
    for (int i = 0; i < 10 && i < log0.size(); i++) check("imp_y", log0[i], imp_exp[i]);

    // step with random gaps, disables and stalls
    log0.delete(); log1.delete();
    p_gap = 20; p_dis = 20; p_stall = 25;
    for (int i = 0; i < 10; i++) send(1);
    p_gap = 0; p_dis = 0; p_stall = 0;
    drain();
    check("step_count", log0.size(), 10);
    for (int i = 0; i < 9 && i < log0.size(); i++) begin
      check("step_y0", log0[i], step0[i]);
      check("step_y1", log1[i], step1[i]);
    end

    // backpressure mid-stream
    log0.delete(); log1.delete();
    for (int x = 1; x <= 20; x++) begin
      send(x);
      if (x == 8) begin
        for (int c = 0; c < 3; c++) begin
          tick();
          y_ready = 0; x_valid = 1; x_in = 9;
          #1;
          if (c == 0) hold = $signed(y_out0);
          else check("bp_hold", $signed(y_out0), hold);
          check("bp_x_ready", x_ready0, 0);
          check("bp_y_valid", y_valid0, 1);
        end
      end
    end
    drain();
    check("bp_count", log0.size(), 20);

    // saturation
    for (int i = 0; i < TAPS; i++) load_buf[i] = 16'h7FFF;
    load_coefs(0);
    run_mode();
    for (int i = 0; i < TAPS; i++) send(16'h7FFF);
    drain();
    check("sat_pos_y0", $signed(y_out0), 64'sd2147483647);
    check("sat_pos_s0", y_sat0, 1);
    check("sat_pos_y1", $signed(y_out1), 32767);
    for (int i = 0; i < TAPS; i++) send(16'h8000);
    drain();
    check("sat_neg_y0", $signed(y_out0), -64'sd2147483648);
    check("sat_neg_s0", y_sat0, 1);
    check("sat_neg_y1", $signed(y_out1), -32768);
    check("sat_neg_s1", y_sat1, 1);
    for (int i = 0; i < TAPS; i++) send(0);
    drain();
    check("sat_zero_s0", y_sat0, 0);
    check("sat_zero_y0", $signed(y_out0), 0);

    // reload with results in flight
    for (int i = 0; i < 3; i++) send(16'h1234);
    for (int i = 0; i < TAPS; i++) load_buf[i] = 1;
    load_coefs(0);
    run_mode();
    send(2);
    drain();
    check("reload_count", log0.size(), 1);
    if (log0.size() > 0) begin
      check("reload_y0", log0[0], 2);
      check("reload_y1", log1[0], 1);
    end

    // randomized rounds, one interrupted by reset
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < TAPS; i++)
        load_buf[i] = (r % 2) ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 255)) - 128;
      p_dis = 15;
      load_coefs(r);
      run_mode();
      p_gap = 20; p_dis = 15; p_stall = 30;
      for (int i = 0; i < 150; i++) begin
        send((r % 2) ? longint'($urandom_range(0, 65535)) : longint'($urandom_range(0, 511)) - 256);
        if (r == 2 && i == 60) begin
          do_reset();
          p_dis = 0;
          load_coefs(0);
          run_mode();
          p_dis = 15;
        end
      end
      p_gap = 0; p_dis = 0; p_stall = 0;
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
